// File: rtl/fetch_unit_pkg.sv
// Shared IF-stage types: the IF/ID pipeline register layout, the bubble
// encoding and the fetch FSM state set.
package fetch_unit_pkg;

    localparam int          FETCH_PC_W      = 9;
    localparam int          FETCH_INSTR_W   = 32;
    localparam logic [31:0] FETCH_NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [FETCH_PC_W-1:0]    Curr_Pc;
        logic [FETCH_INSTR_W-1:0] Curr_Instr;
    } if_id_reg;

    typedef enum logic [1:0] {
        S_ISSUE = 2'd0,
        S_WAIT  = 2'd1,
        S_KILL  = 2'd2,
        S_HOLD  = 2'd3
    } fetch_state_t;

    function automatic if_id_reg make_if_id(input logic [FETCH_PC_W-1:0]    pc,
                                            input logic [FETCH_INSTR_W-1:0] instr);
        if_id_reg r;
        r.Curr_Pc    = pc;
        r.Curr_Instr = instr;
        return r;
    endfunction

endpackage

// File: rtl/fetch_unit_skid_buf.sv
// One-entry holding register for a fetched word that arrived while ID was
// stalled on a valid instruction.
module fetch_skid_buf
    import fetch_unit_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     load,
    input  logic     unload,
    input  logic     clear,
    input  if_id_reg din,
    output if_id_reg dout,
    output logic     full
);

    if_id_reg data_reg;
    logic     full_reg;

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            data_reg <= '0;
            full_reg <= 1'b0;
        end else if (load) begin
            data_reg <= din;
            full_reg <= 1'b1;
        end else if (unload) begin
            full_reg <= 1'b0;
        end
    end

    assign dout = data_reg;
    assign full = full_reg;

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, issues one word fetch at a time over req/rvalid and
// loads the IF/ID register, absorbing stalls through a one-entry skid buffer.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              PC_W      = FETCH_PC_W,
    parameter int              INSTR_W   = FETCH_INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = FETCH_NOP_INSTR
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    output logic               imem_req_o,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic               imem_rvalid_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output if_id_reg           if_id_o,
    output logic               if_id_valid_o
);

    fetch_state_t    state_reg, state_next;
    logic [PC_W-1:0] pc_reg, pc_next;
    if_id_reg        if_id_out_reg, if_id_out_next;
    logic            if_id_valid_reg, if_id_valid_next;

    logic            skid_load, skid_unload, skid_clear, skid_full;
    if_id_reg        skid_dout;
    if_id_reg        fetched, bubble;
    logic [PC_W-1:0] pc_plus4;

    // While in S_WAIT the PC still names the outstanding request.
    assign fetched  = make_if_id(pc_reg, imem_rdata_i);
    assign bubble   = make_if_id('0, NOP_INSTR);
    assign pc_plus4 = pc_reg + PC_W'(4);

    assign imem_req_o = reset && (state_reg == S_ISSUE) && !stall_i && !redirect_i;

    genvar gi;
    generate
        for (gi = 0; gi < PC_W; gi++) begin : g_addr
            assign imem_addr_o[gi] = pc_reg[gi] & imem_req_o;
        end
    endgenerate

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        if_id_out_next   = if_id_out_reg;
        if_id_valid_next = if_id_valid_reg;
        skid_load        = 1'b0;
        skid_unload      = 1'b0;
        skid_clear       = 1'b0;

        if (redirect_i) begin
            if_id_out_next   = bubble;
            if_id_valid_next = 1'b0;
            skid_clear       = 1'b1;
            pc_next          = {redirect_pc_i[PC_W-1:2], 2'b00};
            // A response still in flight must be swallowed before refetching.
            if ((state_reg == S_WAIT || state_reg == S_KILL) && !imem_rvalid_i)
                state_next = S_KILL;
            else
                state_next = S_ISSUE;
        end else begin
            case (state_reg)
                S_ISSUE: begin
                    if (!stall_i)
                        state_next = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        pc_next = pc_plus4;
                        if (stall_i && if_id_valid_reg) begin
                            skid_load  = 1'b1;
                            state_next = S_HOLD;
                        end else begin
                            if_id_out_next   = fetched;
                            if_id_valid_next = 1'b1;
                            state_next       = S_ISSUE;
                        end
                    end
                end
                S_KILL: begin
                    if (imem_rvalid_i)
                        state_next = S_ISSUE;
                end
                S_HOLD: begin
                    if (!stall_i && skid_full) begin
                        if_id_out_next   = skid_dout;
                        if_id_valid_next = 1'b1;
                        skid_unload      = 1'b1;
                        state_next       = S_ISSUE;
                    end
                end
                default: state_next = S_ISSUE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg       <= S_ISSUE;
            pc_reg          <= RESET_PC;
            if_id_out_reg   <= bubble;
            if_id_valid_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            if_id_out_reg   <= if_id_out_next;
            if_id_valid_reg <= if_id_valid_next;
        end
    end

    fetch_skid_buf u_skid (
        .clk    (clk),
        .reset  (reset),
        .load   (skid_load),
        .unload (skid_unload),
        .clear  (skid_clear),
        .din    (fetched),
        .dout   (skid_dout),
        .full   (skid_full)
    );

    assign if_id_o       = if_id_out_reg;
    assign if_id_valid_o = if_id_valid_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by random stall/redirect
// traffic, checked against an in-order delivery model with a behavioural memory.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [8:0]  redirect_pc_i = '0;
    logic        imem_req_o;
    logic [8:0]  imem_addr_o;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    if_id_reg    if_id_o;
    logic        if_id_valid_o;

    fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .if_id_o       (if_id_o),
        .if_id_valid_o (if_id_valid_o)
    );

    always #5 clk = ~clk;

    int compare_count  = 0;
    int mismatch_count = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compare_count++;
        if (got !== exp) begin
            mismatch_count++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Model: memory with fixed latency, expected fetch address, and the
    // ordered list of fetched words not yet presented to ID.
    int          mem_lat = 1;
    bit          mem_busy = 0;
    int          mem_cnt = 0;
    logic [8:0]  mem_addr = '0;
    bit          mem_killed = 0;
    logic [8:0]  exp_fetch = 9'h000;
    if_id_reg    exp_q[$];
    bit          exp_reset = 1;
    bit          exp_bubble = 0;
    bit          last_stall = 0;
    if_id_reg    prev_id = '0;
    bit          prev_v = 0;
    int          req_count = 0;
    bit          last_req = 0;
    logic [8:0]  last_addr = '0;
    if_id_reg    bubble_val;

    task automatic observe();
        if (exp_reset) begin
            check_val("reset_valid", 64'(if_id_valid_o), 64'd0);
            check_val("reset_if_id", 64'(if_id_o), 64'(bubble_val));
            if (!reset)
                check_val("reset_req", 64'({imem_req_o, imem_addr_o}), 64'd0);
        end else if (exp_bubble) begin
            check_val("redir_bubble", 64'({if_id_valid_o, if_id_o}), 64'({1'b0, bubble_val}));
        end else if (last_stall && prev_v) begin
            check_val("stall_hold", 64'({if_id_valid_o, if_id_o}), 64'({1'b1, prev_id}));
        end
        exp_reset  = 0;
        exp_bubble = 0;
        if (if_id_valid_o && (!prev_v || if_id_o !== prev_id)) begin
            check_val("deliver_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                if_id_reg e;
                e = exp_q.pop_front();
                check_val("deliver", 64'(if_id_o), 64'(e));
                $display("DELIVER pc=0x%03h instr=0x%08h", if_id_o.Curr_Pc, if_id_o.Curr_Instr);
            end
        end
        prev_id = if_id_o;
        prev_v  = if_id_valid_o;
    endtask

    task automatic step(input bit rst_n, input bit st, input bit rd,
                        input logic [8:0] rpc, input bit spur);
        bit          rv, resp;
        logic [31:0] data;
        @(negedge clk);
        observe();
        rv   = 0;
        resp = 0;
        data = $urandom;
        if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                rv       = 1;
                resp     = 1;
                data     = 32'hA0 + 32'(mem_addr);
                mem_busy = 0;
            end
        end else if (spur) begin
            rv = 1;
        end
        reset         = rst_n;
        stall_i       = st;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        imem_rvalid_i = rv;
        imem_rdata_i  = data;
        #1;
        if (imem_req_o) begin
            check_val("fetch_addr", 64'(imem_addr_o), 64'(exp_fetch));
            check_val("one_outstanding", 64'(mem_busy), 64'd0);
            req_count++;
        end else begin
            check_val("addr_idle", 64'(imem_addr_o), 64'd0);
        end
        last_req  = imem_req_o;
        last_addr = imem_addr_o;
        if (!rst_n) begin
            exp_q.delete();
            exp_fetch  = 9'h000;
            exp_reset  = 1;
            last_stall = 0;
            if (mem_busy) mem_killed = 1;
        end else begin
            if (resp && !mem_killed && !rd)
                exp_q.push_back(make_if_id(mem_addr, 32'hA0 + 32'(mem_addr)));
            if (resp) mem_killed = 0;
            if (rd) begin
                exp_q.delete();
                exp_fetch  = {rpc[8:2], 2'b00};
                exp_bubble = 1;
                if (mem_busy) mem_killed = 1;
            end
            if (imem_req_o) begin
                mem_busy   = 1;
                mem_cnt    = mem_lat;
                mem_addr   = exp_fetch;
                mem_killed = 0;
                exp_fetch  = exp_fetch + 9'd4;
            end
            last_stall = st && !rd;
        end
    endtask

    task automatic run_until_req(input logic [8:0] addr, input string tag);
        bit found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            step(1, 0, 0, '0, 0);
            if (last_req && last_addr == addr) found = 1;
        end
        check_val(tag, 64'(found), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int r0;
        bubble_val = make_if_id('0, 32'h0000_0013);

        repeat (3) step(0, 0, 0, '0, 0);

        // Reset release with single-cycle memory.
        mem_lat = 1;
        step(1, 0, 0, '0, 0);
        step(1, 0, 0, '0, 0);
        check_val("valid_lat1", 64'(if_id_valid_o), 64'd0);
        step(1, 0, 0, '0, 0);
        check_val("valid_lat2", 64'(if_id_valid_o), 64'd1);
        check_val("first_pc", 64'(if_id_o.Curr_Pc), 64'h000);
        run_until_req(9'h010, "reach_010");

        // Stall while 0x010 is in flight.
        r0 = req_count;
        repeat (5) step(1, 1, 0, '0, 0);
        check_val("stall_no_req", 64'(req_count - r0), 64'd0);
        check_val("stall_pc", 64'(if_id_o.Curr_Pc), 64'h00C);
        run_until_req(9'h014, "resume_014");

        // Redirect while 0x020 is outstanding on 3-cycle memory.
        mem_lat = 3;
        run_until_req(9'h020, "reach_020");
        step(1, 0, 1, 9'h083, 0);
        run_until_req(9'h080, "redir_080");

        // Redirect and stall in the same cycle as rvalid.
        mem_lat = 2;
        run_until_req(9'h088, "reach_088");
        step(1, 0, 0, '0, 0);
        step(1, 1, 1, 9'h100, 0);
        step(1, 0, 0, '0, 0);
        check_val("redir_target", 64'({last_req, last_addr}), 64'({1'b1, 9'h100}));

        // PC wrap.
        mem_lat = 1;
        step(1, 0, 1, 9'h1F8, 0);
        run_until_req(9'h1FC, "reach_1fc");
        run_until_req(9'h000, "wrap_000");

        // Reset while holding a skidded word, with stray rvalids.
        step(1, 1, 0, '0, 0);
        step(1, 1, 0, '0, 0);
        step(0, 1, 0, '0, 1);
        step(1, 1, 0, '0, 1);
        check_val("reset_hold_valid", 64'(if_id_valid_o), 64'd0);
        step(1, 0, 0, '0, 0);
        check_val("reset_first_req", 64'({last_req, last_addr}), 64'({1'b1, 9'h000}));

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bit rst_n, st, rd, spur;
            mem_lat = $urandom_range(1, 4);
            st      = ($urandom % 4) == 0;
            rd      = ($urandom % 20) == 0;
            spur    = ($urandom % 10) == 0;
            rst_n   = !(!mem_busy && ($urandom % 200) == 0);
            step(rst_n, st, rd, 9'($urandom), spur);
        end

        repeat (12) step(1, 0, 0, '0, 0);
        @(negedge clk);
        observe();
        check_val("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
